alu_ctrl_seq: RTL
=================

Name: alu_ctrl_seq

Overview:
Registered, parametrised successor to the single-cycle ALU control decoder, for the pipelined/multi-cycle CPU. Decodes ALUOp_i/funct_i into ALU control, jr and shift-select flags, one cycle after an accepted request, under a valid/ready handshake. Adds shift/logic/sltu decode, illegal-op flagging, pipeline flush and a multi-cycle sequencer for mult/div that stalls issue until the fixed latency expires. Sits between the ID/EX decode stage and the ALU/MDU.

Parameters:
CTRL_W, 4, ALUCtrl_o width; must be >= 4; codes zero-extended into upper bits
MUL_LAT, 4, mult occupancy in cycles (>= 1)
DIV_LAT, 16, div occupancy in cycles (>= 1)
CNT_W, 5, latency counter width; must hold max(MUL_LAT, DIV_LAT)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-high reset
valid_i  in  1  request valid
ready_o  out  1  block can accept a request this cycle
funct_i  in  6  R-type funct field
ALUOp_i  in  3  main-control ALU op class
flush_i  in  1  synchronous pipeline flush
valid_o  out  1  decoded result valid
ready_i  in  1  downstream accepts result
ALUCtrl_o  out  CTRL_W  ALU operation code
jr_o  out  1  instruction is jr
shamt_sel_o  out  1  ALU operand A takes shamt (sll/srl/sra)
illegal_o  out  1  unrecognised funct/ALUOp (valid with valid_o)
busy_o  out  1  mult/div sequencer occupied

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, valid_o=0, ALUCtrl_o=0, jr_o=0, shamt_sel_o=0, illegal_o=0, busy_o=0. An in-flight mult/div is discarded.
- ready_o = (state==IDLE) && !flush_i && (!valid_o || ready_i). Accept = valid_i && ready_o.
- Output register holds all outputs stable while valid_o && !ready_i. valid_o drops the cycle after a handshake unless a new result loads.
- Latency: non-MDU ops produce valid_o exactly 1 cycle after accept.
- ALUOp decode: 000 R-type (funct below); 001 andi->0000; 010 addi->0010; 011 slti->0111; 100 beq->0110; 101 ori->0001; 110 sltiu->1011; 111 lw/sw->0010.
- Funct decode: 100000 add 0010; 100010 sub 0110; 100100 and 0000; 100101 or 0001; 100110 xor 1101; 100111 nor 1100; 101010 slt 0111; 101011 sltu 1011; 000000 sll 1000; 000010 srl 1001; 000011 sra 1010 (shift ops set shamt_sel_o=1); 001000 jr: ALUCtrl 0000, jr_o=1; 011000 mult 1110; 011010 div 1111.
- Unlisted funct: ALUCtrl 0000, jr_o=0, shamt_sel_o=0, illegal_o=1; still completes with valid_o. jr_o/illegal_o/shamt_sel_o are 0 for every non-R-type op.
- States: IDLE, MUL_WAIT, DIV_WAIT. Accepting mult/div: counter=MUL_LAT-1 or DIV_LAT-1; go to MUL_WAIT/DIV_WAIT; busy_o=1; output register not loaded. Each wait cycle counter decrements; when counter==0 (and the cycle's flush_i=0) load result (1110/1111), valid_o=1, return to IDLE, busy_o=0. Total mult latency = MUL_LAT+1 cycles accept-to-valid_o; MUL_LAT=1 gives 2.
- flush_i: next edge valid_o=0, state=IDLE, counter=0, busy_o=0; request presented the same cycle is not accepted (ready_o=0). flush_i overrides counter expiry in the same cycle.
- Counter never wraps; loaded only on MDU accept.

Optional Feature:
ALU_CTRL_MDU_EN. Defined: mult/div sequencer as above. Undefined: no MUL_WAIT/DIV_WAIT states or counter; funct 011000/011010 decode as illegal (ALUCtrl 0000, illegal_o=1, 1-cycle latency); busy_o tied 0; MUL_LAT/DIV_LAT/CNT_W unused.

Test Plan:
Reset mid-div (rst_i high at DIV_WAIT counter=7) -> same-cycle valid_o=0, busy_o=0, ALUCtrl_o=0; first request after release decodes normally.
Back-to-back ALUOp=000 funct 100000,100010,000011, ready_i=1 -> valid_o each cycle from cycle 1, ALUCtrl 0010,0110,1010; shamt_sel_o 0,0,1.
ALUOp=000 funct 001000 then funct 111111 -> jr_o=1 ALUCtrl 0000; then illegal_o=1 jr_o=0.
ready_i=0 for 3 cycles with valid_o=1 (addi, 0010) -> outputs held, ready_o=0, next valid_i not accepted until ready_i=1.
MDU_EN, MUL_LAT=4: mult accepted cycle 0 -> busy_o=1 cycles 1-4, ready_o=0, valid_o=1 ALUCtrl 1110 cycle 5; DIV_LAT=16 -> valid_o cycle 17.
flush_i during MUL_WAIT counter=2 with valid_i=1 -> next cycle IDLE, busy_o=0, valid_o=0, request not accepted; MDU_EN undefined: mult -> illegal_o=1 after 1 cycle.

Source files
------------

// File: rtl/alu_ctrl_if.sv
// Request/result bundle between the ID/EX decode stage and alu_ctrl_seq.
// Handshake: a request transfers on a rising edge where valid_i && ready_o; a result transfers where valid_o && ready_i; a producer holds valid and payload stable until it transfers.
interface alu_ctrl_if #(
  parameter int CTRL_W = 4
);
  logic              valid_i;
  logic              ready_o;
  logic [5:0]        funct_i;
  logic [2:0]        ALUOp_i;
  logic              flush_i;
  logic              valid_o;
  logic              ready_i;
  logic [CTRL_W-1:0] ALUCtrl_o;
  logic              jr_o;
  logic              shamt_sel_o;
  logic              illegal_o;
  logic              busy_o;
  logic [1:0]        state_o;

  modport slave (
    input  valid_i, funct_i, ALUOp_i, flush_i, ready_i,
    output ready_o, valid_o, ALUCtrl_o, jr_o, shamt_sel_o, illegal_o, busy_o, state_o
  );

  modport master (
    output valid_i, funct_i, ALUOp_i, flush_i, ready_i,
    input  ready_o, valid_o, ALUCtrl_o, jr_o, shamt_sel_o, illegal_o, busy_o, state_o
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with handshake, flush and an optional mult/div
// occupancy sequencer enabled by defining ALU_CTRL_MDU_EN.
module alu_ctrl_seq #(
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 16,
  parameter int CNT_W   = 5
) (
  input logic      clk_i,
  input logic      rst_i,
  alu_ctrl_if.slave bus
);

  if (CTRL_W < 4 || MUL_LAT < 1 || DIV_LAT < 1 ||
      MUL_LAT > (1 << CNT_W) || DIV_LAT > (1 << CNT_W)) begin : g_bad_param
    $error("alu_ctrl_seq: illegal parameter combination");
  end

  logic [3:0] dec_ctrl;
  logic       dec_jr, dec_sh, dec_ill;
`ifdef ALU_CTRL_MDU_EN
  logic       dec_mul, dec_div;
`endif

  // Pure decode of the request; registered below only on accept.
  always_comb begin
    dec_ctrl = 4'b0000;
    dec_jr   = 1'b0;
    dec_sh   = 1'b0;
    dec_ill  = 1'b0;
`ifdef ALU_CTRL_MDU_EN
    dec_mul  = 1'b0;
    dec_div  = 1'b0;
`endif
    case (bus.ALUOp_i)
      3'b000: begin
        case (bus.funct_i)
          6'b100000: dec_ctrl = 4'b0010;
          6'b100010: dec_ctrl = 4'b0110;
          6'b100100: dec_ctrl = 4'b0000;
          6'b100101: dec_ctrl = 4'b0001;
          6'b100110: dec_ctrl = 4'b1101;
          6'b100111: dec_ctrl = 4'b1100;
          6'b101010: dec_ctrl = 4'b0111;
          6'b101011: dec_ctrl = 4'b1011;
          6'b000000: begin dec_ctrl = 4'b1000; dec_sh = 1'b1; end
          6'b000010: begin dec_ctrl = 4'b1001; dec_sh = 1'b1; end
          6'b000011: begin dec_ctrl = 4'b1010; dec_sh = 1'b1; end
          6'b001000: dec_jr = 1'b1;
`ifdef ALU_CTRL_MDU_EN
          6'b011000: begin dec_ctrl = 4'b1110; dec_mul = 1'b1; end
          6'b011010: begin dec_ctrl = 4'b1111; dec_div = 1'b1; end
`endif
          default:   dec_ill = 1'b1;
        endcase
      end
      3'b001:  dec_ctrl = 4'b0000;
      3'b010:  dec_ctrl = 4'b0010;
      3'b011:  dec_ctrl = 4'b0111;
      3'b100:  dec_ctrl = 4'b0110;
      3'b101:  dec_ctrl = 4'b0001;
      3'b110:  dec_ctrl = 4'b1011;
      default: dec_ctrl = 4'b0010;
    endcase
  end

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              jr_q, jr_d;
  logic              sh_q, sh_d;
  logic              ill_q, ill_d;
  logic              idle;
  logic              ready;
  logic              accept;

  assign ready  = idle && !bus.flush_i && (!valid_q || bus.ready_i);
  assign accept = bus.valid_i && ready;

`ifdef ALU_CTRL_MDU_EN
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_WAIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign idle = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q && !bus.ready_i;
    ctrl_d  = ctrl_q;
    jr_d    = jr_q;
    sh_d    = sh_q;
    ill_d   = ill_q;
    // Flush wins over both a new accept and a counter expiring this cycle.
    if (bus.flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (dec_mul) begin
              state_d = MUL_WAIT;
              cnt_d   = CNT_W'(MUL_LAT - 1);
            end else if (dec_div) begin
              state_d = DIV_WAIT;
              cnt_d   = CNT_W'(DIV_LAT - 1);
            end else begin
              valid_d = 1'b1;
              ctrl_d  = CTRL_W'(dec_ctrl);
              jr_d    = dec_jr;
              sh_d    = dec_sh;
              ill_d   = dec_ill;
            end
          end
        end
        MUL_WAIT, DIV_WAIT: begin
          // valid_q is already 0 here: accept required the old result to leave.
          if (cnt_q == '0) begin
            state_d = IDLE;
            valid_d = 1'b1;
            ctrl_d  = CTRL_W'((state_q == MUL_WAIT) ? 4'b1110 : 4'b1111);
            jr_d    = 1'b0;
            sh_d    = 1'b0;
            ill_d   = 1'b0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy_o  = (state_q != IDLE);
  assign bus.state_o = state_q;
`else
  assign idle = 1'b1;

  always_comb begin
    valid_d = valid_q && !bus.ready_i;
    ctrl_d  = ctrl_q;
    jr_d    = jr_q;
    sh_d    = sh_q;
    ill_d   = ill_q;
    if (bus.flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      ctrl_d  = CTRL_W'(dec_ctrl);
      jr_d    = dec_jr;
      sh_d    = dec_sh;
      ill_d   = dec_ill;
    end
  end

  // Without the sequencer the block never leaves its idle state (code 0).
  assign bus.busy_o  = 1'b0;
  assign bus.state_o = 2'd0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      jr_q    <= 1'b0;
      sh_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      jr_q    <= jr_d;
      sh_q    <= sh_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.ready_o     = ready;
  assign bus.valid_o     = valid_q;
  assign bus.ALUCtrl_o   = ctrl_q;
  assign bus.jr_o        = jr_q;
  assign bus.shamt_sel_o = sh_q;
  assign bus.illegal_o   = ill_q;

endmodule
